instr_fetch_decode: RTL and testbench

- Upstream control stage for the register-file/ALU datapath (regfile plus ALU top).
- Fetches 16-bit instructions from instruction memory over a req/valid handshake and keeps the program counter.
- Decodes each instruction into the datapath's control inputs: opCode, regEnable, a_select, b_select, immediate, use_imm.
- Each decoded instruction is presented for exactly one execute cycle, then the next instruction is fetched.

---
 rtl/instr_fetch_decode_pkg.sv | 55 +++++
 rtl/instr_field_decode.sv | 96 +++++++++
 rtl/instr_fetch_decode.sv | 134 +++++++++++++
 tb/tb_instr_fetch_decode.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_decode_pkg.sv
// Shared definitions for the instruction fetch/decode stage: ALU opcodes,
// instruction field positions and the fetch FSM state encoding.
package instr_fetch_decode_pkg;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned EXT_MSB = 7;
  localparam int unsigned EXT_LSB = 4;
  localparam int unsigned RS_MSB  = 3;
  localparam int unsigned RS_LSB  = 0;

  localparam logic [3:0] FMT_REG   = 4'b0000;
  localparam logic [3:0] FMT_SHIFT = 4'b1000;

  localparam logic [7:0] OPC_NOP    = 8'h00;
  localparam logic [7:0] OPC_AND    = 8'h01;
  localparam logic [7:0] OPC_OR     = 8'h02;
  localparam logic [7:0] OPC_XOR    = 8'h03;
  localparam logic [7:0] OPC_ADDCU  = 8'h04;
  localparam logic [7:0] OPC_ADD    = 8'h05;
  localparam logic [7:0] OPC_ADDU   = 8'h06;
  localparam logic [7:0] OPC_ADDC   = 8'h07;
  localparam logic [7:0] OPC_CMPU   = 8'h08;
  localparam logic [7:0] OPC_SUB    = 8'h09;
  localparam logic [7:0] OPC_CMP    = 8'h0B;
  localparam logic [7:0] OPC_CMPUI  = 8'h0C;
  localparam logic [7:0] OPC_NOT    = 8'h0F;
  localparam logic [7:0] OPC_ANDI   = 8'h10;
  localparam logic [7:0] OPC_ORI    = 8'h20;
  localparam logic [7:0] OPC_XORI   = 8'h30;
  localparam logic [7:0] OPC_ADDCUI = 8'h40;
  localparam logic [7:0] OPC_ADDI   = 8'h50;
  localparam logic [7:0] OPC_ADDUI  = 8'h60;
  localparam logic [7:0] OPC_ADDCI  = 8'h70;
  localparam logic [7:0] OPC_LSHI   = 8'h80;
  localparam logic [7:0] OPC_RSHI   = 8'h81;
  localparam logic [7:0] OPC_ALSHI  = 8'h82;
  localparam logic [7:0] OPC_ARSHI  = 8'h83;
  localparam logic [7:0] OPC_LSH    = 8'h84;
  localparam logic [7:0] OPC_RSH    = 8'h85;
  localparam logic [7:0] OPC_ALSH   = 8'h86;
  localparam logic [7:0] OPC_ARSH   = 8'h87;
  localparam logic [7:0] OPC_SUBI   = 8'h90;
  localparam logic [7:0] OPC_CMPI   = 8'hB0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    EXEC  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational mapping of a 16-bit instruction word onto the
// datapath control fields; undefined encodings decode to a NOP with illegal set.
module instr_field_decode
  import instr_fetch_decode_pkg::*;
(
  input  logic [15:0] instr_i,
  output logic [7:0]  op_code_o,
  output logic        write_o,
  output logic [3:0]  a_select_o,
  output logic [3:0]  b_select_o,
  output logic [15:0] immediate_o,
  output logic        use_imm_o,
  output logic        illegal_o
);

  logic [3:0] op;
  logic [3:0] rd;
  logic [3:0] ext;
  logic [3:0] rs;
  logic [7:0] imm8;

  assign op   = instr_i[OP_MSB:OP_LSB];
  assign rd   = instr_i[RD_MSB:RD_LSB];
  assign ext  = instr_i[EXT_MSB:EXT_LSB];
  assign rs   = instr_i[RS_MSB:RS_LSB];
  assign imm8 = instr_i[EXT_MSB:RS_LSB];

  always_comb begin
    op_code_o   = OPC_NOP;
    write_o     = 1'b0;
    a_select_o  = rd;
    b_select_o  = '0;
    immediate_o = '0;
    use_imm_o   = 1'b0;
    illegal_o   = 1'b0;
    case (op)
      FMT_REG: begin
        case (ext)
          4'h0, 4'h8, 4'hB: begin
            op_code_o  = {4'h0, ext};
            b_select_o = rs;
          end
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hF: begin
            op_code_o  = {4'h0, ext};
            b_select_o = rs;
            write_o    = 1'b1;
          end
          4'hC: begin
            op_code_o   = OPC_CMPUI;
            use_imm_o   = 1'b1;
            immediate_o = {12'h000, rs};
          end
          default: illegal_o = 1'b1;
        endcase
      end
      FMT_SHIFT: begin
        case (ext)
          4'h4, 4'h5, 4'h6, 4'h7: begin
            op_code_o  = {FMT_SHIFT, ext};
            b_select_o = rs;
            write_o    = 1'b1;
          end
          4'h0, 4'h1, 4'h2, 4'h3: begin
            op_code_o   = {FMT_SHIFT, ext};
            use_imm_o   = 1'b1;
            immediate_o = {12'h000, rs};
            write_o     = 1'b1;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      4'b0101, 4'b0111, 4'b1001: begin
        op_code_o   = {op, 4'h0};
        use_imm_o   = 1'b1;
        immediate_o = {{8{imm8[7]}}, imm8};
        write_o     = 1'b1;
      end
      4'b1011: begin
        op_code_o   = {op, 4'h0};
        use_imm_o   = 1'b1;
        immediate_o = {{8{imm8[7]}}, imm8};
      end
      4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110: begin
        op_code_o   = {op, 4'h0};
        use_imm_o   = 1'b1;
        immediate_o = {8'h00, imm8};
        write_o     = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
    if (illegal_o) begin
      a_select_o = '0;
    end
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode control stage: fetches one instruction per loop over a req/valid
// handshake and presents its decoded controls for exactly one EXEC cycle.
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_valid,
  input  logic [15:0]     imem_data,
  output logic [7:0]      opCode,
  output logic [15:0]     regEnable,
  output logic [3:0]      a_select,
  output logic [3:0]      b_select,
  output logic [15:0]     immediate,
  output logic            use_imm,
  output logic            illegal,
  output logic [PC_W-1:0] pc
);

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     instr_q;
  logic [15:0]     instr_d;
  logic            req_q;
  logic [7:0]      opcode_q;
  logic [15:0]     regen_q;
  logic [3:0]      asel_q;
  logic [3:0]      bsel_q;
  logic [15:0]     imm_q;
  logic            useimm_q;
  logic            illegal_q;

  logic            accept;
  logic [7:0]      dec_opcode;
  logic            dec_write;
  logic [3:0]      dec_asel;
  logic [3:0]      dec_bsel;
  logic [15:0]     dec_imm;
  logic            dec_useimm;
  logic            dec_illegal;

  assign accept  = (state_q == WAIT) && imem_valid;
  assign instr_d = accept ? imem_data : instr_q;

  // Decoding the word being latched lets the EXEC-cycle outputs be registered
  // while still reflecting the latched instruction.
  instr_field_decode u_field_decode (
    .instr_i     (instr_d),
    .op_code_o   (dec_opcode),
    .write_o     (dec_write),
    .a_select_o  (dec_asel),
    .b_select_o  (dec_bsel),
    .immediate_o (dec_imm),
    .use_imm_o   (dec_useimm),
    .illegal_o   (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      req_q     <= 1'b0;
      opcode_q  <= OPC_NOP;
      regen_q   <= '0;
      asel_q    <= '0;
      bsel_q    <= '0;
      imm_q     <= '0;
      useimm_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      opcode_q  <= OPC_NOP;
      regen_q   <= '0;
      asel_q    <= '0;
      bsel_q    <= '0;
      imm_q     <= '0;
      useimm_q  <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        FETCH: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (imem_valid) begin
            state_q   <= EXEC;
            req_q     <= 1'b0;
            opcode_q  <= dec_opcode;
            regen_q   <= dec_write ? (16'h0001 << dec_asel) : 16'h0000;
            asel_q    <= dec_asel;
            bsel_q    <= dec_bsel;
            imm_q     <= dec_imm;
            useimm_q  <= dec_useimm;
            illegal_q <= dec_illegal;
          end
        end
        EXEC: begin
          pc_q <= pc_q + PC_W'(1);
          if (run) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign imem_req  = req_q;
  assign pc        = pc_q;
  assign opCode    = opcode_q;
  assign regEnable = regen_q;
  assign a_select  = asel_q;
  assign b_select  = bsel_q;
  assign immediate = imm_q;
  assign use_imm   = useimm_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: directed programs with hand-computed
// decodes, a behavioural instruction memory with per-word latency, and a monitor.
module tb_instr_fetch_decode;

  typedef struct {
    logic [7:0]  opc;
    logic [15:0] re;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [15:0] imm;
    logic        ui;
    logic        ill;
    logic [15:0] pc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic [7:0]  opCode;
  logic [15:0] regEnable;
  logic [3:0]  a_select;
  logic [3:0]  b_select;
  logic [15:0] immediate;
  logic        use_imm;
  logic        illegal;
  logic [15:0] pc;

  exp_t        exp_q[$];
  logic [15:0] mem [16];
  int unsigned dly [16];
  logic        hold_valid;
  logic        mon_en;
  int          n_cmp;
  int          n_err;

  instr_fetch_decode #(.PC_W(16), .RESET_PC(16'hFFFD)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .opCode     (opCode),
    .regEnable  (regEnable),
    .a_select   (a_select),
    .b_select   (b_select),
    .immediate  (immediate),
    .use_imm    (use_imm),
    .illegal    (illegal),
    .pc         (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic issue(input logic [15:0] addr, input logic [15:0] word, input int unsigned d,
                       input logic [7:0] opc, input logic [15:0] re, input logic [3:0] a,
                       input logic [3:0] b, input logic [15:0] imm, input logic ui, input logic ill);
    exp_t e;
    mem[addr[3:0]] = word;
    dly[addr[3:0]] = d;
    e.opc = opc; e.re = re; e.a = a; e.b = b; e.imm = imm; e.ui = ui; e.ill = ill; e.pc = addr;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string nm, input int unsigned budget);
    int unsigned i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    chk(nm, (i < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Instruction memory: valid after dly[] cycles of WAIT, sampled by the DUT only in WAIT.
  initial begin : memory
    int unsigned cnt;
    cnt = 0;
    imem_valid = 1'b0;
    imem_data  = '0;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1) cnt++;
      else cnt = 0;
      imem_data  = mem[imem_addr[3:0]];
      imem_valid = ((imem_req === 1'b1) && (cnt > dly[imem_addr[3:0]] + 1)) || hold_valid;
    end
  end

  initial begin : monitor
    logic        exec_nx;
    logic        prev_req;
    logic [15:0] prev_addr;
    exp_t        e;
    prev_req  = 1'b0;
    prev_addr = '0;
    forever begin
      @(posedge clk);
      exec_nx = (imem_req === 1'b1) && (imem_valid === 1'b1) && !reset;
      @(negedge clk);
      if (mon_en) begin
        chk("addr_eq_pc", {16'h0, imem_addr}, {16'h0, pc});
        if (imem_req && prev_req) chk("addr_stable", {16'h0, imem_addr}, {16'h0, prev_addr});
        if (exec_nx) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_exec: got opCode %h pc %h expected no EXEC", opCode, pc);
          end else begin
            e = exp_q.pop_front();
            chk("opCode",    {24'h0, opCode},    {24'h0, e.opc});
            chk("regEnable", {16'h0, regEnable}, {16'h0, e.re});
            chk("a_select",  {28'h0, a_select},  {28'h0, e.a});
            chk("b_select",  {28'h0, b_select},  {28'h0, e.b});
            chk("immediate", {16'h0, immediate}, {16'h0, e.imm});
            chk("use_imm",   {31'h0, use_imm},   {31'h0, e.ui});
            chk("illegal",   {31'h0, illegal},   {31'h0, e.ill});
            chk("exec_pc",   {16'h0, pc},        {16'h0, e.pc});
            chk("exec_req",  {31'h0, imem_req},  32'h0);
          end
        end else begin
          chk("quiet_outside_exec", {7'h0, illegal, opCode, regEnable}, 32'h0);
        end
      end
      prev_req  = imem_req;
      prev_addr = imem_addr;
    end
  end

  initial begin : stimulus
    n_cmp = 0;
    n_err = 0;
    mon_en = 1'b0;
    hold_valid = 1'b0;
    reset = 1'b1;
    run = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 16'h0000;
      dly[i] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pc",  {16'h0, pc}, 32'h0000FFFD);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_ctl", {opCode, regEnable, a_select, b_select}, 32'h0);
    chk("rst_imm", {immediate, 14'h0, use_imm, illegal}, 32'h0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Program runs across the pc wrap from 16'hFFFD.
    issue(16'hFFFD, 16'h0152, 0, 8'h05, 16'h0002, 4'h1, 4'h2, 16'h0000, 1'b0, 1'b0);
    issue(16'hFFFE, 16'h53FF, 0, 8'h50, 16'h0008, 4'h3, 4'h0, 16'hFFFF, 1'b1, 1'b0);
    issue(16'hFFFF, 16'h12F0, 0, 8'h10, 16'h0004, 4'h2, 4'h0, 16'h00F0, 1'b1, 1'b0);
    issue(16'h0000, 16'h04B5, 0, 8'h0B, 16'h0000, 4'h4, 4'h5, 16'h0000, 1'b0, 1'b0);
    issue(16'h0001, 16'h8737, 0, 8'h83, 16'h0080, 4'h7, 4'h0, 16'h0007, 1'b1, 1'b0);
    issue(16'h0002, 16'hF000, 0, 8'h00, 16'h0000, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b1);
    issue(16'h0003, 16'h03CA, 4, 8'h0C, 16'h0000, 4'h3, 4'h0, 16'h000A, 1'b1, 1'b0);
    issue(16'h0004, 16'h8A45, 0, 8'h84, 16'h0400, 4'hA, 4'h5, 16'h0000, 1'b0, 1'b0);
    issue(16'h0005, 16'h00A0, 0, 8'h00, 16'h0000, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b1);
    issue(16'h0006, 16'h9C80, 0, 8'h90, 16'h1000, 4'hC, 4'h0, 16'hFF80, 1'b1, 1'b0);
    @(negedge clk);
    run = 1'b1;
    wait_drain("prog_drain", 200);
    run = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("idle_after_prog_pc",  {16'h0, pc}, 32'h00000007);
    chk("idle_after_prog_req", {31'h0, imem_req}, 32'h0);

    // One-cycle run pulse: the fetch still completes through EXEC.
    issue(16'h0007, 16'h0F3C, 1, 8'h03, 16'h8000, 4'hF, 4'hC, 16'h0000, 1'b0, 1'b0);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_drain("pulse_drain", 50);
    repeat (6) @(negedge clk);
    #1;
    chk("pulse_pc",  {16'h0, pc}, 32'h00000008);
    chk("pulse_req", {31'h0, imem_req}, 32'h0);

    // Reset on the same edge as imem_valid in WAIT: no EXEC follows.
    mem[8] = 16'h0152;
    dly[8] = 3;
    run = 1'b1;
    begin : find_valid
      int unsigned k;
      for (k = 0; k < 50; k++) begin
        @(negedge clk); #1;
        if (imem_valid) break;
      end
      chk("rst_wait_valid_seen", (k < 50) ? 32'd1 : 32'd0, 32'd1);
    end
    reset = 1'b1;
    run = 1'b0;
    hold_valid = 1'b1;
    @(negedge clk); #1;
    chk("midrst_pc",  {16'h0, pc}, 32'h0000FFFD);
    chk("midrst_req", {31'h0, imem_req}, 32'h0);
    chk("midrst_ctl", {opCode, regEnable, a_select, b_select}, 32'h0);
    chk("midrst_imm", {immediate, 14'h0, use_imm, illegal}, 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("late_valid_pc",  {16'h0, pc}, 32'h0000FFFD);
    chk("late_valid_req", {31'h0, imem_req}, 32'h0);
    hold_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
